// File: rtl/lock_seq_ctrl.sv
// Digit-entry sequencer for the combination lock: compares entered BCD digits
// against a stored code, counts failures, enforces a timed lockout, and reprograms the code.
module lock_seq_ctrl #(
  parameter int                     NDIGITS      = 6,
  parameter logic [4*NDIGITS-1:0]   DEFAULT_CODE = 24'h320474,
  parameter int                     MAX_FAIL     = 3,
  parameter int                     LOCKOUT_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       relock,
  input  logic       change_req,
  output logic       open_o,
  output logic       closed_o,
  output logic       lockout_o,
  output logic       prog_o,
  output logic       bad_digit_o,
  output logic [2:0] digit_idx_o,
  output logic [2:0] fail_cnt_o
);
  localparam int CW = 4*NDIGITS;
  localparam int TW = $clog2(LOCKOUT_CYC) + 1;

  typedef enum logic [2:0] {S_ENTER, S_OPEN, S_CLOSED, S_LOCKOUT, S_PROG} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_code;
  logic [CW-1:0]   r_shadow;
  logic [2:0]      r_idx;
  logic            r_miss;
  logic [2:0]      r_fail;
  logic [TW-1:0]   r_timer;
  logic            r_bad;

  logic            w_acc;
  logic            w_bad;
  logic            w_last;
  logic [3:0]      w_ref;
  logic [2:0]      w_fail_inc;
  logic [CW-1:0]   w_shift;

  assign w_acc      = digit_valid && (digit <= 4'd9);
  assign w_bad      = digit_valid && (digit >  4'd9);
  assign w_last     = (r_idx == 3'(NDIGITS-1));
  assign w_fail_inc = r_fail + 3'd1;
  assign w_shift    = {r_shadow[CW-5:0], digit};

  // Code nibble for the current position, first digit in the MS nibble.
  always_comb begin
    w_ref = r_code[4*(NDIGITS-1-int'(r_idx)) +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_ENTER;
      r_code   <= DEFAULT_CODE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_miss   <= 1'b0;
      r_fail   <= '0;
      r_timer  <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_bad <= w_bad;
      case (r_state)
        S_ENTER: begin
          if (relock) begin
            r_idx  <= '0;
            r_miss <= 1'b0;
          end else if (w_acc) begin
            if (w_last) begin
              r_idx  <= '0;
              r_miss <= 1'b0;
              if (!r_miss && (digit == w_ref)) begin
                r_state <= S_OPEN;
                r_fail  <= '0;
              end else begin
                if (r_fail != 3'(MAX_FAIL)) r_fail <= w_fail_inc;
                if (w_fail_inc == 3'(MAX_FAIL)) begin
                  r_state <= S_LOCKOUT;
                  r_timer <= TW'(LOCKOUT_CYC-1);
                end else begin
                  r_state <= S_CLOSED;
                end
              end
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_miss <= r_miss | (digit != w_ref);
            end
          end
        end
        S_OPEN: begin
          if (relock) begin
            r_state <= S_ENTER;
          end else if (change_req) begin
            r_state <= S_PROG;
            r_idx   <= '0;
          end
        end
        S_CLOSED: begin
          if (relock) r_state <= S_ENTER;
        end
        S_LOCKOUT: begin
          if (r_timer == '0) begin
            r_state <= S_ENTER;
            r_fail  <= '0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_PROG: begin
          // Shadow only lands in r_code on a complete pass; relock drops it.
          if (relock) begin
            r_state <= S_ENTER;
            r_idx   <= '0;
          end else if (w_acc) begin
            r_shadow <= w_shift;
            if (w_last) begin
              r_code  <= w_shift;
              r_state <= S_ENTER;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_ENTER;
      endcase
    end
  end

  assign open_o      = (r_state == S_OPEN);
  assign closed_o    = (r_state == S_CLOSED);
  assign lockout_o   = (r_state == S_LOCKOUT);
  assign prog_o      = (r_state == S_PROG);
  assign bad_digit_o = r_bad;
  assign digit_idx_o = ((r_state == S_ENTER) || (r_state == S_PROG)) ? r_idx : 3'd0;
  assign fail_cnt_o  = r_fail;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed plus randomized bench for lock_seq_ctrl against a queue-based reference model.
module tb_lock_seq_ctrl;
  localparam int N = 6, MAXF = 3, LCYC = 16;
  localparam int M_ENTER = 0, M_OPEN = 1, M_CLOSED = 2, M_LOCK = 3, M_PROG = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       digit_valid = 1'b0, relock = 1'b0, change_req = 1'b0;
  logic [3:0] digit = '0;
  logic       open_o, closed_o, lockout_o, prog_o, bad_digit_o;
  logic [2:0] digit_idx_o, fail_cnt_o;

  int n_tests = 0, n_fail = 0;

  // reference model state
  int m_mode, m_fails, m_left;
  bit m_bad;
  int m_code[N];
  int q[$];

  lock_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .relock(relock), .change_req(change_req), .open_o(open_o), .closed_o(closed_o),
    .lockout_o(lockout_o), .prog_o(prog_o), .bad_digit_o(bad_digit_o),
    .digit_idx_o(digit_idx_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    logic [23:0] dc;
    dc = 24'h320474;
    for (int i = 0; i < N; i++) m_code[i] = int'(dc[23-4*i -: 4]);
    m_mode = M_ENTER; m_fails = 0; m_left = 0; m_bad = 0;
    q.delete();
  endfunction

  function automatic void m_step(input bit dv, input int d, input bit rl, input bit cr);
    bit acc, match;
    acc   = dv && d <= 9;
    m_bad = dv && d > 9;
    case (m_mode)
      M_ENTER:
        if (rl) q.delete();
        else if (acc) begin
          q.push_back(d);
          if (q.size() == N) begin
            match = 1;
            for (int i = 0; i < N; i++) if (q[i] != m_code[i]) match = 0;
            q.delete();
            if (match) begin m_mode = M_OPEN; m_fails = 0; end
            else begin
              m_fails++;
              if (m_fails == MAXF) begin m_mode = M_LOCK; m_left = LCYC; end
              else m_mode = M_CLOSED;
            end
          end
        end
      M_OPEN:
        if (rl) m_mode = M_ENTER;
        else if (cr) begin m_mode = M_PROG; q.delete(); end
      M_CLOSED: if (rl) m_mode = M_ENTER;
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_ENTER; m_fails = 0; end
      end
      M_PROG:
        if (rl) begin m_mode = M_ENTER; q.delete(); end
        else if (acc) begin
          q.push_back(d);
          if (q.size() == N) begin
            for (int i = 0; i < N; i++) m_code[i] = q[i];
            q.delete();
            m_mode = M_ENTER;
          end
        end
      default: m_mode = M_ENTER;
    endcase
  endfunction

  function automatic int exp_vec();
    logic [10:0] e;
    int idx;
    idx = (m_mode == M_ENTER || m_mode == M_PROG) ? q.size() : 0;
    e = {m_mode == M_OPEN, m_mode == M_CLOSED, m_mode == M_LOCK, m_mode == M_PROG,
         m_bad, 3'(idx), 3'(m_fails)};
    return int'(e);
  endfunction

  function automatic int obs_vec();
    logic [10:0] o;
    o = {open_o, closed_o, lockout_o, prog_o, bad_digit_o, digit_idx_o, fail_cnt_o};
    return int'(o);
  endfunction

  task automatic step(input bit dv, input int d, input bit rl, input bit cr);
    digit_valid = dv; digit = 4'(d); relock = rl; change_req = cr;
    @(posedge clk);
    m_step(dv, d, rl, cr);
    #1;
    chk("step", obs_vec(), exp_vec());
    digit_valid = 0; relock = 0; change_req = 0;
  endtask

  task automatic enter(input logic [23:0] c);
    for (int i = 0; i < N; i++) step(1, int'(c[23-4*i -: 4]), 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_reset();
    chk("reset", obs_vec(), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, r, d;
    bit dv;
    m_reset();
    #3;
    do_reset();

    // correct code opens; idx counts during entry
    for (int i = 0; i < N-1; i++) begin
      logic [23:0] c = 24'h320474;
      step(1, int'(c[23-4*i -: 4]), 0, 0);
      chk("idx_cnt", int'(digit_idx_o), i+1);
    end
    step(1, 4, 0, 0);
    chk("open1", int'(open_o), 1);
    chk("fail0", int'(fail_cnt_o), 0);
    step(0, 0, 1, 0);

    // two wrong codes
    enter(24'h320475);
    chk("closed1", int'(closed_o), 1);
    chk("fail1", int'(fail_cnt_o), 1);
    step(0, 0, 1, 0);
    enter(24'h120474);
    chk("fail2", int'(fail_cnt_o), 2);
    step(0, 0, 1, 0);

    // third failure: lockout for exactly LCYC cycles, inputs ignored
    enter(24'h370474);
    n = 0;
    while (lockout_o && n < 40) begin
      n++;
      step(1, $urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("lock_len", n, LCYC);
    chk("lock_fail_clr", int'(fail_cnt_o), 0);

    // illegal digit mid-entry
    step(1, 3, 0, 0); step(1, 2, 0, 0);
    step(1, 12, 0, 0);
    chk("bad_pulse", int'(bad_digit_o), 1);
    chk("bad_idx", int'(digit_idx_o), 2);
    step(0, 0, 0, 0);
    chk("bad_clr", int'(bad_digit_o), 0);
    step(1, 0, 0, 0); step(1, 4, 0, 0); step(1, 7, 0, 0); step(1, 4, 0, 0);
    chk("open_after_bad", int'(open_o), 1);

    // reprogram, old code fails, new code opens, reset restores default
    step(0, 0, 0, 1);
    chk("prog", int'(prog_o), 1);
    enter(24'h112233);
    chk("prog_done", int'(prog_o), 0);
    enter(24'h320474);
    chk("old_closed", int'(closed_o), 1);
    step(0, 0, 1, 0);
    enter(24'h112233);
    chk("new_open", int'(open_o), 1);
    do_reset();
    enter(24'h320474);
    chk("dflt_open", int'(open_o), 1);

    // relock with digit drops the digit; aborted programming keeps the code
    step(0, 0, 1, 0);
    step(1, 3, 0, 0); step(1, 7, 0, 0);
    step(1, 5, 1, 0);
    chk("relock_idx", int'(digit_idx_o), 0);
    enter(24'h320474);
    chk("open_relock", int'(open_o), 1);
    step(0, 0, 0, 1);
    step(1, 9, 0, 0); step(1, 9, 0, 0); step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    chk("abort_exit", int'(prog_o), 0);
    enter(24'h320474);
    chk("abort_keep", int'(open_o), 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 299);
      if (r == 0) do_reset();
      else begin
        dv = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 7 && q.size() < N && m_mode == M_ENTER) d = m_code[q.size()];
        else if ($urandom_range(0, 9) < 2) d = $urandom_range(10, 15);
        else d = $urandom_range(0, 9);
        step(dv, d, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
